// File: rtl/bcd3_count_ctrl.sv
// Run/stop/terminal-count controller for a 3-digit BCD counter; define AUTO_RELOAD_EN for periodic reload mode.
// All strobes registered: first cnt_inc lands DIV cycles after start is sampled; commands act on the next edge, no backpressure.
module bcd3_count_ctrl #(
  parameter int unsigned DIV = 10,
  parameter int unsigned PW  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic [11:0] target,
  input  logic [3:0]  hun,
  input  logic [3:0]  ten,
  input  logic [3:0]  uni,
  output logic        cnt_inc,
  output logic        cnt_clr,
  output logic        busy,
  output logic        done,
  output logic        wrap
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [11:0]   tgt_q, tgt_d;
  logic          cnt_inc_q, cnt_inc_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic          wrap_q, wrap_d;
`ifdef AUTO_RELOAD_EN
  logic          done_q, done_d;
`endif

  logic [11:0] digits;
  logic        digits_bcd;
  logic        match;
  logic        settled;
  logic        tick;

  assign digits     = {hun, ten, uni};
  assign digits_bcd = (hun <= 4'd9) && (ten <= 4'd9) && (uni <= 4'd9);
  assign match      = digits_bcd && (digits == tgt_q);
  // Digits lag an inc/clr strobe by one edge, so only compare once they have settled.
  assign settled    = !cnt_inc_q && !cnt_clr_q;
  assign tick       = (presc_q == PRESC_MAX);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    tgt_d     = tgt_q;
    cnt_inc_d = 1'b0;
    cnt_clr_d = 1'b0;
    wrap_d    = 1'b0;
`ifdef AUTO_RELOAD_EN
    done_d    = 1'b0;
`endif
    if (clear) begin
      cnt_clr_d = 1'b1;
      state_d   = S_IDLE;
      presc_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (!stop && start) begin
            tgt_d   = target;
            state_d = S_RUN;
            presc_d = '0;
          end
        end
        S_PAUSE: begin
          if (!stop && start) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_PAUSE;
          end else if (settled && match) begin
`ifdef AUTO_RELOAD_EN
            cnt_clr_d = 1'b1;
            done_d    = 1'b1;
            presc_d   = '0;
`else
            state_d   = S_DONE;
`endif
          end else if (tick) begin
            cnt_inc_d = 1'b1;
            wrap_d    = (digits == 12'h999);
            presc_d   = '0;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      tgt_q     <= '0;
      cnt_inc_q <= 1'b0;
      cnt_clr_q <= 1'b0;
      wrap_q    <= 1'b0;
`ifdef AUTO_RELOAD_EN
      done_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tgt_q     <= tgt_d;
      cnt_inc_q <= cnt_inc_d;
      cnt_clr_q <= cnt_clr_d;
      wrap_q    <= wrap_d;
`ifdef AUTO_RELOAD_EN
      done_q    <= done_d;
`endif
    end
  end

  assign cnt_inc = cnt_inc_q;
  assign cnt_clr = cnt_clr_q;
  assign wrap    = wrap_q;
  assign busy    = (state_q == S_RUN);
`ifdef AUTO_RELOAD_EN
  assign done    = done_q;
`else
  assign done    = (state_q == S_DONE);
`endif

endmodule

// File: tb/tb_bcd3_count_ctrl.sv
// Bench for bcd3_count_ctrl (DIV=4) with a behavioural BCD counter datapath closing the digit loop.
module tb_bcd3_count_ctrl;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic [11:0] target = 12'h000;
  logic [3:0]  hun, ten, uni;
  logic        cnt_inc, cnt_clr, busy, done, wrap;

  logic        ld = 1'b0;
  logic [11:0] ld_val = 12'h000;
  logic [11:0] dig;
  logic [4:0]  outs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd3_count_ctrl #(.DIV(DIV), .PW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .target(target), .hun(hun), .ten(ten), .uni(uni),
    .cnt_inc(cnt_inc), .cnt_clr(cnt_clr), .busy(busy), .done(done), .wrap(wrap)
  );

  assign {hun, ten, uni} = dig;
  // {inc, clr, busy, done, wrap}
  assign outs = {cnt_inc, cnt_clr, busy, done, wrap};

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] h, t, u;
    {h, t, u} = v;
    if (u >= 4'd9) begin
      u = 4'd0;
      if (t >= 4'd9) begin
        t = 4'd0;
        h = (h >= 4'd9) ? 4'd0 : h + 4'd1;
      end else t = t + 4'd1;
    end else u = u + 4'd1;
    return {h, t, u};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       dig <= 12'h000;
    else if (ld)      dig <= ld_val;
    else if (cnt_clr) dig <= 12'h000;
    else if (cnt_inc) dig <= bcd_inc(dig);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic s, input logic p, input logic c, input logic [11:0] t);
    start = s; stop = p; clear = c; target = t;
    step();
    start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  task automatic load(input logic [11:0] v);
    ld = 1'b1; ld_val = v;
    step();
    ld = 1'b0;
  endtask

  task automatic run_until_done(input int max, output int incs, output int wraps,
                                output int stray, output int cyc, output bit ok);
    incs = 0; wraps = 0; stray = 0; cyc = 0; ok = 1'b0;
    for (int k = 1; k <= max; k++) begin
      step();
      cyc = k;
      if (cnt_inc) incs++;
      if (wrap && cnt_inc) wraps++;
      if (wrap && !cnt_inc) stray++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic        st;
    logic        sp;
    logic        cl;
    logic [11:0] tgt;
    logic [4:0]  exp;
  } vec_t;

  vec_t tbl[25];

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int incs, wraps, stray, cyc, cnt;
    bit ok;

    // Count from 000 to target 005 at DIV=4: inc on edges 4,8,..,20, DONE on edge 22.
    for (int i = 0; i < 25; i++) begin
      tbl[i].st = 1'b0; tbl[i].sp = 1'b0; tbl[i].cl = 1'b0; tbl[i].tgt = 12'h000;
      if (i >= 22)                  tbl[i].exp = 5'b00010;
      else if (i > 0 && i % 4 == 0) tbl[i].exp = 5'b10100;
      else                          tbl[i].exp = 5'b00100;
    end
    tbl[0].st = 1'b1; tbl[0].tgt = 12'h005;
    tbl[2].st = 1'b1; tbl[2].tgt = 12'h003;   // start in RUN must not resample target
    tbl[23].sp = 1'b1;                         // stop in DONE ignored

    step(); step();
    check("reset_outs", outs, 5'b00000);
    rst_n = 1'b1;
    step();
    check("post_reset_outs", outs, 5'b00000);

`ifndef AUTO_RELOAD_EN
    for (int i = 0; i < 25; i++) begin
      apply(tbl[i].st, tbl[i].sp, tbl[i].cl, tbl[i].tgt);
      check($sformatf("vec%0d", i), outs, tbl[i].exp);
    end

    apply(1'b0, 1'b0, 1'b1, 12'h000);
    check("clear_from_done", outs, 5'b01000);
    step();
    check("clear_pulse_end", outs, 5'b00000);

    // Stop with prescaler at 2, hold, resume: inc DIV-2 cycles later.
    apply(1'b1, 1'b0, 1'b0, 12'h009);
    check("run_start", outs, 5'b00100);
    step(); step();
    apply(1'b0, 1'b1, 1'b0, 12'h000);
    check("stop_to_pause", outs, 5'b00000);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (cnt_inc || busy) cnt++;
    end
    check("pause_quiet", cnt, 0);
    apply(1'b1, 1'b0, 1'b0, 12'h000);
    check("resume", outs, 5'b00100);
    step();
    check("resume_plus1", outs, 5'b00100);
    step();
    check("resume_inc", outs, 5'b10100);
    step(); step(); step();
    apply(1'b1, 1'b0, 1'b1, 12'h000);
    check("clear_start_run", outs, 5'b01000);
    step();
    check("clear_no_inc", outs, 5'b00000);

    apply(1'b1, 1'b1, 1'b0, 12'h000);
    check("start_stop_idle", outs, 5'b00000);
    step();
    check("start_stop_idle2", outs, 5'b00000);

    apply(1'b1, 1'b0, 1'b0, 12'h000);
    check("match_at_start_run", outs, 5'b00100);
    step();
    check("match_at_start_done", outs, 5'b00010);

    load(12'h995);
    apply(1'b1, 1'b0, 1'b0, 12'h999);
    run_until_done(60, incs, wraps, stray, cyc, ok);
    check("t999_done", ok, 1'b1);
    check("t999_incs", incs, 4);
    check("t999_wraps", wraps, 0);
    check("t999_cycles", cyc, 18);

    apply(1'b1, 1'b0, 1'b0, 12'h002);
    run_until_done(60, incs, wraps, stray, cyc, ok);
    check("t002_done", ok, 1'b1);
    check("t002_incs", incs, 3);
    check("t002_wraps", wraps, 1);
    check("t002_stray_wrap", stray, 0);
    check("t002_cycles", cyc, 14);

    apply(1'b0, 1'b0, 1'b1, 12'h000);
    step();
    load(12'h00A);
    apply(1'b1, 1'b0, 1'b0, 12'h00A);
    step(); step();
    check("non_bcd_no_match", outs, 5'b00100);
    apply(1'b0, 1'b0, 1'b1, 12'h000);
    step();
`else
    cnt = 0;
    apply(1'b1, 1'b0, 1'b0, 12'h003);
    begin
      int n_inc, n_clr, n_done, n_idle, first_clr, n_done_solo;
      n_inc = 0; n_clr = 0; n_done = 0; n_idle = 0; first_clr = 0; n_done_solo = 0;
      for (int k = 1; k <= 42; k++) begin
        step();
        if (cnt_inc) n_inc++;
        if (cnt_clr) begin
          n_clr++;
          if (first_clr == 0) first_clr = k;
        end
        if (done) n_done++;
        if (done && !cnt_clr) n_done_solo++;
        if (!busy) n_idle++;
      end
      check("ar_incs", n_inc, 9);
      check("ar_clrs", n_clr, 3);
      check("ar_first_clr", first_clr, 14);
      check("ar_done_pulses", n_done, 3);
      check("ar_done_solo", n_done_solo, 0);
      check("ar_busy_held", n_idle, 0);
    end
    apply(1'b0, 1'b0, 1'b1, 12'h000);
    step();
`endif

    // Async reset mid-RUN, caught on the cycle cnt_inc is high.
    apply(1'b1, 1'b0, 1'b0, 12'h999);
    step(); step(); step();
    step();
    check("pre_reset_inc", outs, 5'b10100);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", outs, 5'b00000);
    step(); step();
    rst_n = 1'b1;
    step();
    check("after_reset_idle", outs, 5'b00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
